booth_seq_ctrl: RTL and testbench
=================================

BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 The block SHALL have one parameter: EARLY_EXIT, default 1, where 1 enables early termination when all remaining multiplier digits are zero.
REQ-002 clk  input  1  Clock for the block; all state updates occur on the rising edge.
REQ-003 clr  input  1  Reset, asynchronous and active-high.
REQ-004 start  input  1  Request to begin a multiply; sampled only in IDLE.
REQ-005 cancel  input  1  Abort of an in-progress multiply.
REQ-006 a  input  32  Signed multiplicand.
REQ-007 b  input  32  Signed multiplier.
REQ-008 busy  output  1  High while in RUN.
REQ-009 done  output  1  One-cycle completion pulse.
REQ-010 hilo_we  output  1  HI/LO write enable; identical to done.
REQ-011 hi  output  32  Registered product bits [63:32].
REQ-012 lo  output  32  Registered product bits [31:0].

Function
REQ-013 The block SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE with start=1 and cancel=0 SHALL perform the following at the edge, then enter RUN:
- mcand <= a
- mreg (33-bit) <= {b,1'b0}
- acc (64-bit) <= 0
- cnt (4-bit) <= 0
REQ-015 IDLE with cancel=1 SHALL stay in IDLE and ignore start.
REQ-016 Each RUN cycle SHALL decode triplet mreg[2:0] into a partial product:
- 000/111 -> 0
- 001/010 -> +mcand
- 011 -> +2*mcand
- 100 -> -2*mcand
- 101/110 -> -mcand
REQ-017 Each RUN cycle SHALL sign-extend that partial product to 64 bits, shift it left by 2*cnt, and add it to acc modulo 2^64.
REQ-018 Each RUN cycle SHALL also arithmetic-shift mreg right by 2 and increment cnt.
REQ-019 RUN SHALL go to DONE after the cycle in which cnt=15, i.e. 16 iterations.
REQ-020 With EARLY_EXIT=1, RUN SHALL also go to DONE after any cycle whose shifted mreg is all-zeros or all-ones.
REQ-021 In every case, {hi,lo} SHALL equal the exact signed 64-bit product a*b.
REQ-022 The final accumulated value SHALL be loaded into {hi,lo} on the RUN->DONE edge.
REQ-023 DONE SHALL assert done=1 and hilo_we=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-024 start asserted in DONE SHALL be ignored.
REQ-025 Latency, with start sampled at edge T:
- EARLY_EXIT=0: done high in cycle T+17.
- EARLY_EXIT=1: done high in cycle T+1+N, N = 1..16 iterations executed.
REQ-026 start and input changes to a and b during RUN or DONE SHALL be ignored; operands are latched at acceptance.
REQ-027 cancel=1 in RUN SHALL return the FSM to IDLE at the next edge.
REQ-028 A cancelled multiply SHALL produce no done or hilo_we pulse, and hi/lo SHALL keep their previous values.
REQ-029 cancel=1 in DONE SHALL have no effect; the pulse still completes.
REQ-030 busy SHALL be 1 exactly in RUN, done SHALL be 1 exactly in DONE, and both SHALL be registered outputs.
REQ-031 hi/lo SHALL change only on the RUN->DONE edge or on reset.

Reset
REQ-032 clr=1 SHALL immediately, without waiting for clk, force:
- FSM to IDLE
- busy=0, done=0, hilo_we=0
- hi=0, lo=0
- acc=0, mreg=0, cnt=0
REQ-033 clr asserted mid-RUN SHALL abandon the operation with no done pulse.
REQ-034 After clr deasserts, the first start sampled in IDLE SHALL be accepted normally.

Verification
REQ-035 EARLY_EXIT=0, a=3, b=5, start for one cycle -> busy for 16 cycles, done/hilo_we at T+17, hi=0x00000000, lo=0x0000000F.
REQ-036 a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-037 EARLY_EXIT=1, a=0xFFFFFFF9 (-7), b=6 -> 2 iterations, done at T+3, hi=0xFFFFFFFF, lo=0xFFFFFFD6.
REQ-038 EARLY_EXIT=1, b=0 and separately b=0xFFFFFFFF with a=9 -> each finishes in 1 iteration (done at T+2), results 0 and hi=0xFFFFFFFF/lo=0xFFFFFFF7.
REQ-039 Cancel and restart:
- After 3 with 5 completes, start 7 by 7 and pulse cancel in the 5th RUN cycle.
- Required: no done pulse, busy=0 next cycle, hi/lo stay at 0x0/0xF.
- A new start with 7 by 7 then gives lo=0x31.
REQ-040 Reset mid-operation: assert clr asynchronously mid-RUN -> busy, done, hi and lo are 0 before the next clk edge, and there is no later done pulse.

Source files
------------

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-4 Booth multiplier controller: 32x32 signed -> 64-bit HI/LO, one digit per cycle.
// Latency 1+N cycles (N = 16, or fewer with EARLY_EXIT); cancel aborts RUN without touching HI/LO.
module booth_seq_ctrl #(
   parameter int EARLY_EXIT = 1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic        cancel,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic        hilo_we,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_mcand;
   logic [32:0] r_mreg;
   logic [63:0] r_acc;
   logic [3:0]  r_cnt;

   logic [63:0] w_mc_ext;
   logic [63:0] w_pp;
   logic [63:0] w_acc_nxt;
   logic [32:0] w_mreg_nxt;
   logic        w_last;

   always_comb begin
      w_mc_ext = {{32{r_mcand[31]}}, r_mcand};
      case (r_mreg[2:0])
         3'b001, 3'b010: w_pp = w_mc_ext;
         3'b011:         w_pp = w_mc_ext << 1;
         3'b100:         w_pp = -(w_mc_ext << 1);
         3'b101, 3'b110: w_pp = -w_mc_ext;
         default:        w_pp = 64'd0;
      endcase
      w_acc_nxt  = r_acc + (w_pp << {r_cnt, 1'b0});
      w_mreg_nxt = {{2{r_mreg[32]}}, r_mreg[32:2]};
      // A uniform remaining multiplier only yields 000/111 triplets, i.e. zero partial products.
      w_last = (r_cnt == 4'd15) ||
               ((EARLY_EXIT != 0) && ((w_mreg_nxt == '0) || (w_mreg_nxt == '1)));
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= S_IDLE;
         r_mcand <= '0;
         r_mreg  <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hilo_we <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && !cancel) begin
                  r_mcand <= a;
                  r_mreg  <= {b, 1'b0};
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (cancel) begin
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_acc  <= w_acc_nxt;
                  r_mreg <= w_mreg_nxt;
                  r_cnt  <= r_cnt + 4'd1;
                  if (w_last) begin
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     hilo_we  <= 1'b1;
                     {hi, lo} <= w_acc_nxt;
                     r_state  <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               hilo_we <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               hilo_we <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl: one instance without and one with early exit.
// Directed operands with hand-computed products; a monitor pops expectations on each done pulse.
module tb_booth_seq_ctrl;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          t0;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        clr;
   logic [1:0]  start_v, cancel_v, busy_v, done_v, we_v;
   logic [31:0] a_v [2];
   logic [31:0] b_v [2];
   logic [31:0] hi_v [2];
   logic [31:0] lo_v [2];

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t q0 [$];
   exp_t q1 [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   booth_seq_ctrl #(.EARLY_EXIT(0)) dut0 (
      .clk(clk), .clr(clr), .start(start_v[0]), .cancel(cancel_v[0]),
      .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .hilo_we(we_v[0]), .hi(hi_v[0]), .lo(lo_v[0])
   );

   booth_seq_ctrl #(.EARLY_EXIT(1)) dut1 (
      .clk(clk), .clr(clr), .start(start_v[1]), .cancel(cancel_v[1]),
      .a(a_v[1]), .b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .hilo_we(we_v[1]), .hi(hi_v[1]), .lo(lo_v[1])
   );

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   // Cycle T+k is the clock period ending at edge T+k, so a pulse raised at edge E sits in cycle E+1.
   always @(negedge clk) begin : mon
      exp_t e;
      bit   have;
      if (!clr) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("hilo_we_vs_done%0d", d), 64'(we_v[d]), 64'(done_v[d]));
            if (done_v[d]) begin
               have = 1'b0;
               if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
               if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
               if (!have) begin
                  total++;
                  bad++;
                  $display("FAIL spurious_done%0d: got done=1 want no pulse (t=%0t)", d, $time);
               end else begin
                  chk($sformatf("hi%0d", d), 64'(hi_v[d]), 64'(e.hi));
                  chk($sformatf("lo%0d", d), 64'(lo_v[d]), 64'(e.lo));
                  chk($sformatf("latency%0d", d), 64'(cyc - e.t0 + 1), 64'(e.lat));
                  chk($sformatf("busy_in_done%0d", d), 64'(busy_v[d]), 64'd0);
               end
            end
         end
      end
   end

   task automatic launch(input int d, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el, input int lat, input bit push);
      exp_t e;
      @(negedge clk);
      a_v[d] = av;
      b_v[d] = bv;
      start_v[d] = 1'b1;
      e.hi = eh; e.lo = el; e.t0 = cyc + 1; e.lat = lat;
      if (push) begin
         if (d == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      @(negedge clk);
      start_v[d] = 1'b0;
      a_v[d] = ~av;
      b_v[d] = ~bv;
   endtask

   // Counts busy cycles, injects a stray start pulse in RUN/DONE, waits for the result to retire.
   task automatic finish(input int d, input int lat);
      int  nb;
      bit  ok;
      nb = busy_v[d] ? 1 : 0;
      ok = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) start_v[d] = 1'b1;
         if (k == 2) start_v[d] = 1'b0;
         if (busy_v[d]) nb++;
         if (k >= 2 && qsize(d) == 0 && !busy_v[d]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL timeout%0d: got no completion within 60 cycles want done pulse", d);
      end
      chk($sformatf("busy_cycles%0d", d), 64'(nb), 64'(lat - 1));
   endtask

   task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el, input int lat);
      launch(d, av, bv, eh, el, lat, 1'b1);
      finish(d, lat);
   endtask

   initial begin
      clr = 1'b1;
      start_v = '0;
      cancel_v = '0;
      for (int d = 0; d < 2; d++) begin
         a_v[d] = '0;
         b_v[d] = '0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_busy", 64'(busy_v[d]), 64'd0);
         chk("rst_done", 64'(done_v[d]), 64'd0);
         chk("rst_we",   64'(we_v[d]),   64'd0);
         chk("rst_hi",   64'(hi_v[d]),   64'd0);
         chk("rst_lo",   64'(lo_v[d]),   64'd0);
      end
      clr = 1'b0;

      // Full 16-iteration instance
      run_op(0, 32'd3, 32'd5, 32'h0, 32'hF, 17);
      launch(0, 32'd7, 32'd7, 32'h0, 32'h0, 17, 1'b0);
      repeat (4) @(negedge clk);
      cancel_v[0] = 1'b1;
      @(negedge clk);
      cancel_v[0] = 1'b0;
      chk("cancel_busy", 64'(busy_v[0]), 64'd0);
      chk("cancel_done", 64'(done_v[0]), 64'd0);
      chk("cancel_hi",   64'(hi_v[0]),   64'h0);
      chk("cancel_lo",   64'(lo_v[0]),   64'hF);
      repeat (20) @(negedge clk);
      chk("cancel_hold_lo", 64'(lo_v[0]), 64'hF);
      run_op(0, 32'd7, 32'd7, 32'h0, 32'h31, 17);
      run_op(0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 17);
      run_op(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 17);
      run_op(0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 17);
      run_op(0, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 17);

      // Early-exit instance
      run_op(1, 32'd3, 32'd5, 32'h0, 32'hF, 3);
      run_op(1, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 3);
      run_op(1, 32'd9, 32'd0, 32'h0, 32'h0, 2);
      run_op(1, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF7, 2);
      run_op(1, 32'd7, 32'd7, 32'h0, 32'h31, 3);
      run_op(1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 17);

      // Asynchronous clear mid-RUN
      launch(0, 32'd3, 32'd5, 32'h0, 32'h0, 17, 1'b0);
      repeat (5) @(negedge clk);
      #2 clr = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("aclr_busy", 64'(busy_v[d]), 64'd0);
         chk("aclr_done", 64'(done_v[d]), 64'd0);
         chk("aclr_hi",   64'(hi_v[d]),   64'd0);
         chk("aclr_lo",   64'(lo_v[d]),   64'd0);
      end
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
      repeat (25) @(negedge clk);
      chk("post_clr_busy", 64'(busy_v[0]), 64'd0);
      run_op(0, 32'd3, 32'd5, 32'h0, 32'hF, 17);
      run_op(1, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 3);

      repeat (3) @(negedge clk);
      chk("q0_drained", 64'(q0.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
